sfifo_wr_arbiter: RTL and testbench



---
 rtl/sfifo_wr_arbiter_pkg.sv | 10 +
 rtl/sfifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/sfifo_wr_arbiter.sv | 100 ++++++++++
 tb/tb_sfifo_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_wr_arbiter_pkg.sv
// Shared types for the sfifo write-side arbiter.
package sfifo_wr_arbiter_pkg;

   // Arbiter FSM: IDLE picks an owner, LOCKED streams the owner's beats.
   typedef enum logic {
      StIdle   = 1'b0,
      StLocked = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sfifo_wr_arbiter_rr_pick.sv
// Round-robin pick: one-hot winner is the first request at or after ptr, wrapping.
module sfifo_wr_arbiter_rr_pick #(
   parameter int unsigned NIN = 4
) (
   input  logic [NIN-1:0]         req,
   input  logic [$clog2(NIN)-1:0] ptr,
   output logic [NIN-1:0]         winner
);

   localparam int unsigned PW = $clog2(NIN);

   logic [PW:0] idx;

   // Scan from the farthest offset down to ptr so the nearest request overwrites.
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int i = NIN - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(NIN)) begin
            idx = idx - (PW+1)'(NIN);
         end
         if (req[idx[PW-1:0]]) begin
            winner                = '0;
            winner[idx[PW-1:0]]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin arbiter sharing one sfifo write port among NIN packet sources.
// The grant is held for a whole packet so packets never interleave in the FIFO.
module sfifo_wr_arbiter
   import sfifo_wr_arbiter_pkg::*;
#(
   parameter int unsigned NIN      = 4,
   parameter int unsigned BW       = 8,
   parameter bit          OPT_LOCK = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [NIN-1:0]    i_valid,
   input  logic [NIN*BW-1:0] i_data,
   input  logic [NIN-1:0]    i_last,
   output logic [NIN-1:0]    o_ready,
   output logic              o_wr,
   output logic [BW:0]       o_wr_data,
   input  logic              i_full,
   output logic [NIN-1:0]    o_grant,
   output logic              o_busy
);

   localparam int unsigned PW = $clog2(NIN);

   arb_state_t       state;
   logic [PW-1:0]    ptr;
   logic [NIN-1:0]   winner;
   logic [PW-1:0]    owner_idx;
   logic             owner_valid;
   logic             owner_last;
   logic [BW-1:0]    owner_data;
   logic             xfer;
   logic [PW-1:0]    next_ptr;

   sfifo_wr_arbiter_rr_pick #(
      .NIN (NIN)
   ) u_rr_pick (
      .req    (i_valid),
      .ptr    (ptr),
      .winner (winner)
   );

   // Owner mux: select valid/last/data of the one-hot granted source.
   always_comb begin
      owner_idx   = '0;
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      for (int k = 0; k < NIN; k++) begin
         if (o_grant[k]) begin
            owner_idx   = PW'(k);
            owner_valid = i_valid[k];
            owner_last  = i_last[k];
            owner_data  = i_data[k*BW +: BW];
         end
      end
   end

   // Write path: accept from the owner only while the FIFO has room.
   always_comb begin
      xfer      = (state == StLocked) && owner_valid && !i_full;
      o_ready   = ((state == StLocked) && !i_full) ? o_grant : '0;
      o_wr      = xfer;
      o_wr_data = {owner_last, owner_data};
      // The source that just finished drops to lowest priority next round.
      next_ptr  = (owner_idx == PW'(NIN - 1)) ? '0 : owner_idx + 1'b1;
   end

   // Arbitration FSM with registered grant, pointer and busy flag.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state   <= StIdle;
         o_grant <= '0;
         ptr     <= '0;
         o_busy  <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (|i_valid) begin
                  o_grant <= winner;
                  state   <= StLocked;
                  o_busy  <= 1'b1;
               end
            end
            StLocked: begin
               if (xfer && (!OPT_LOCK || owner_last)) begin
                  o_grant <= '0;
                  state   <= StIdle;
                  o_busy  <= 1'b0;
                  ptr     <= next_ptr;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Self-checking bench for sfifo_wr_arbiter: directed scenarios plus random
// traffic against a packet-level reference model, for OPT_LOCK=1 and OPT_LOCK=0.
module tb_sfifo_wr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  valid;
   logic [31:0] data;
   logic [3:0]  last;
   logic        full;

   logic [3:0]  lk_ready, nl_ready;
   logic        lk_wr, nl_wr;
   logic [8:0]  lk_wr_data, nl_wr_data;
   logic [3:0]  lk_grant, nl_grant;
   logic        lk_busy, nl_busy;

   int n_checks = 0;
   int n_pass   = 0;

   sfifo_wr_arbiter #(.NIN(4), .BW(8), .OPT_LOCK(1'b1)) u_lk (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
      .o_ready(lk_ready), .o_wr(lk_wr), .o_wr_data(lk_wr_data), .i_full(full),
      .o_grant(lk_grant), .o_busy(lk_busy)
   );

   sfifo_wr_arbiter #(.NIN(4), .BW(8), .OPT_LOCK(1'b0)) u_nl (
      .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_data(data), .i_last(last),
      .o_ready(nl_ready), .o_wr(nl_wr), .o_wr_data(nl_wr_data), .i_full(full),
      .o_grant(nl_grant), .o_busy(nl_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the port and where the round-robin search starts.
   // Index 0 models OPT_LOCK=1, index 1 models OPT_LOCK=0.
   bit m_busy [2];
   int m_owner[2];
   int m_ptr  [2];

   function automatic int first_from(input int p, input logic [3:0] v);
      for (int o = 0; o < 4; o++) begin
         if (v[(p + o) % 4]) return (p + o) % 4;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (!rst_n) begin
            m_busy[c] <= 1'b0;
            m_ptr[c]  <= 0;
         end else if (!m_busy[c]) begin
            if (valid != 4'b0) begin
               m_busy[c]  <= 1'b1;
               m_owner[c] <= first_from(m_ptr[c], valid);
            end
         end else if (valid[m_owner[c]] && !full) begin
            if (c == 1 || last[m_owner[c]]) begin
               m_busy[c] <= 1'b0;
               m_ptr[c]  <= (m_owner[c] + 1) % 4;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      valid = '0; last = '0; data = '0; full = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if ({lk_grant, lk_ready, lk_wr, lk_busy} !== 10'b0)
         $display("FAIL reset_lk got grant=%b ready=%b wr=%b busy=%b want all 0",
                  lk_grant, lk_ready, lk_wr, lk_busy);
      else n_pass++;
      n_checks++;
      if ({nl_grant, nl_ready, nl_wr, nl_busy} !== 10'b0)
         $display("FAIL reset_nl got grant=%b ready=%b wr=%b busy=%b want all 0",
                  nl_grant, nl_ready, nl_wr, nl_busy);
      else n_pass++;
   endtask

   task automatic test_single();
      logic [7:0] a [3];
      a[0] = 8'hA1; a[1] = 8'hA2; a[2] = 8'hA3;
      do_reset();
      valid = 4'b0010; data = {16'h0, a[0], 8'h0}; last = 4'b0000;
      #1;
      n_checks++;
      if (lk_wr !== 1'b0 || lk_grant !== 4'b0)
         $display("FAIL single_idle got wr=%b grant=%b want 0/0000", lk_wr, lk_grant);
      else n_pass++;
      for (int b = 0; b < 3; b++) begin
         step();
         data = {16'h0, a[b], 8'h0};
         last = (b == 2) ? 4'b0010 : 4'b0000;
         #1;
         n_checks++;
         if (lk_grant !== 4'b0010 || lk_wr !== 1'b1 || lk_ready !== 4'b0010 ||
             lk_wr_data !== {(b == 2), a[b]})
            $display("FAIL single_beat%0d got grant=%b wr=%b ready=%b data=%h want 0010/1/0010/%h",
                     b, lk_grant, lk_wr, lk_ready, lk_wr_data, {(b == 2), a[b]});
         else n_pass++;
      end
      step();
      valid = '0; last = '0;
      #1;
      n_checks++;
      if (lk_grant !== 4'b0 || lk_busy !== 1'b0 || lk_wr !== 1'b0)
         $display("FAIL single_end got grant=%b busy=%b wr=%b want 0000/0/0",
                  lk_grant, lk_busy, lk_wr);
      else n_pass++;
   endtask

   task automatic test_contention();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int bc[4] = '{0, 0, 0, 0};
      int nrec = 0;
      logic [3:0] prev_grant = '0;
      do_reset();
      valid = 4'hF;
      for (int t = 0; t < 60 && nrec < 5; t++) begin
         for (int k = 0; k < 4; k++) begin
            data[k*8 +: 8] = 8'((k << 4) | bc[k]);
            last[k]        = (bc[k] == 1);
         end
         #1;
         if (lk_grant !== 4'b0 && prev_grant === 4'b0) begin
            n_checks++;
            if (lk_grant !== 4'(1 << exp_order[nrec]))
               $display("FAIL contention_grant%0d got %b want %b",
                        nrec, lk_grant, 4'(1 << exp_order[nrec]));
            else n_pass++;
            nrec++;
         end
         if (lk_wr === 1'b1 && nrec > 0) begin
            n_checks++;
            if (lk_wr_data[7:4] !== 4'(exp_order[nrec-1]))
               $display("FAIL contention_tag got %0d want %0d",
                        lk_wr_data[7:4], exp_order[nrec-1]);
            else n_pass++;
            bc[exp_order[nrec-1]] = (bc[exp_order[nrec-1]] + 1) % 2;
         end
         prev_grant = lk_grant;
         step();
      end
      n_checks++;
      if (nrec !== 5) $display("FAIL contention_timeout got %0d tenures want 5", nrec);
      else n_pass++;
      valid = '0;
   endtask

   task automatic test_backpressure();
      int sb = 0;
      do_reset();
      for (int t = 0; t < 12; t++) begin
         valid = (sb < 4) ? 4'b0100 : 4'b0000;
         data  = {8'h0, 8'(8'hB0 + sb), 16'h0};
         last  = (sb == 3) ? 4'b0100 : 4'b0000;
         full  = (t >= 3 && t < 6);
         #1;
         if (full) begin
            n_checks++;
            if (lk_wr !== 1'b0 || lk_ready !== 4'b0 || lk_grant !== 4'b0100)
               $display("FAIL bp_full t=%0d got wr=%b ready=%b grant=%b want 0/0000/0100",
                        t, lk_wr, lk_ready, lk_grant);
            else n_pass++;
         end
         if (lk_wr === 1'b1) begin
            n_checks++;
            if (lk_wr_data !== {(sb == 3), 8'(8'hB0 + sb)})
               $display("FAIL bp_beat%0d got %h want %h", sb, lk_wr_data,
                        {(sb == 3), 8'(8'hB0 + sb)});
            else n_pass++;
            sb++;
         end
         step();
      end
      full = 1'b0;
      n_checks++;
      if (sb !== 4) $display("FAIL bp_count got %0d beats want 4", sb);
      else n_pass++;
      valid = '0;
   endtask

   task automatic test_nolock();
      do_reset();
      valid = 4'b0101; last = '0;
      data  = {8'h0, 8'h20, 8'h0, 8'h00};
      for (int t = 0; t < 8; t++) begin
         #1;
         n_checks++;
         if (nl_wr !== ((t % 2) == 1))
            $display("FAIL nolock_wr t=%0d got %b want %b", t, nl_wr, ((t % 2) == 1));
         else n_pass++;
         if ((t % 2) == 1) begin
            n_checks++;
            if (nl_wr_data[7:4] !== (((t % 4) == 1) ? 4'd0 : 4'd2))
               $display("FAIL nolock_src t=%0d got %0d want %0d", t, nl_wr_data[7:4],
                        (((t % 4) == 1) ? 0 : 2));
            else n_pass++;
         end
         step();
      end
      valid = '0;
   endtask

   task automatic test_reset_mid();
      int sb = 0;
      do_reset();
      for (int t = 0; t < 10 && sb < 2; t++) begin
         valid = 4'b1000;
         data  = {8'(8'h30 + sb), 24'h0};
         last  = (sb == 3) ? 4'b1000 : 4'b0000;
         #1;
         if (lk_wr === 1'b1) sb++;
         step();
      end
      rst_n = 1'b0;
      valid = 4'b1001;
      last  = '0;
      step();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (sb !== 2 || lk_grant !== 4'b0 || lk_busy !== 1'b0)
         $display("FAIL rstmid_clear got beats=%0d grant=%b busy=%b want 2/0000/0",
                  sb, lk_grant, lk_busy);
      else n_pass++;
      step();
      #1;
      n_checks++;
      if (lk_grant !== 4'b0001)
         $display("FAIL rstmid_next got grant=%b want 0001", lk_grant);
      else n_pass++;
      valid = '0;
   endtask

   task automatic test_random();
      logic [3:0] eg;
      do_reset();
      for (int t = 0; t < 400; t++) begin
         step();
         valid = 4'($urandom);
         last  = 4'($urandom);
         data  = $urandom;
         full  = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 49) != 0);
         #1;
         eg = m_busy[0] ? 4'(1 << m_owner[0]) : 4'b0;
         n_checks++;
         if ({lk_grant, lk_ready, lk_wr, lk_busy} !==
             {eg, (full ? 4'b0 : eg), (m_busy[0] && valid[m_owner[0]] && !full), m_busy[0]})
            $display("FAIL rand_lk t=%0d got g=%b r=%b w=%b b=%b want g=%b busy=%b",
                     t, lk_grant, lk_ready, lk_wr, lk_busy, eg, m_busy[0]);
         else n_pass++;
         if (m_busy[0] && valid[m_owner[0]] && !full) begin
            n_checks++;
            if (lk_wr_data !== {last[m_owner[0]], data[m_owner[0]*8 +: 8]})
               $display("FAIL rand_lk_data t=%0d got %h want %h", t, lk_wr_data,
                        {last[m_owner[0]], data[m_owner[0]*8 +: 8]});
            else n_pass++;
         end
         eg = m_busy[1] ? 4'(1 << m_owner[1]) : 4'b0;
         n_checks++;
         if ({nl_grant, nl_ready, nl_wr, nl_busy} !==
             {eg, (full ? 4'b0 : eg), (m_busy[1] && valid[m_owner[1]] && !full), m_busy[1]})
            $display("FAIL rand_nl t=%0d got g=%b r=%b w=%b b=%b want g=%b busy=%b",
                     t, nl_grant, nl_ready, nl_wr, nl_busy, eg, m_busy[1]);
         else n_pass++;
         if (m_busy[1] && valid[m_owner[1]] && !full) begin
            n_checks++;
            if (nl_wr_data !== {last[m_owner[1]], data[m_owner[1]*8 +: 8]})
               $display("FAIL rand_nl_data t=%0d got %h want %h", t, nl_wr_data,
                        {last[m_owner[1]], data[m_owner[1]*8 +: 8]});
            else n_pass++;
         end
      end
      rst_n = 1'b1;
      valid = '0;
   endtask

   initial begin
      rst_n = 1'b0; valid = '0; last = '0; data = '0; full = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_nolock();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
